// File: rtl/cim_act_serializer_if.sv
// ----------------------------------------------------------------------------
// cim_act_serializer_if
//   Handshake and bit-serial bus of the CIM activation serializer.
//
//   Signals:
//     in_valid / in_ready : activation pair handshake (upstream -> serializer)
//     act_c / act_d       : ACT_W-bit activation words, lanes c and d
//     c_n / d_n           : active-low select bits driving the OAI array
//     bit_valid           : current beat (c_n, d_n, bit_idx, bit_last) is valid
//     out_ready           : array/accumulator consumes the current beat
//     bit_idx             : bit position of the current beat within the word
//     bit_last            : current beat is the final bit of the word
//     busy                : a word is loaded and not yet fully consumed
//
//   Modports:
//     master : upstream producer / downstream consumer side (e.g. testbench)
//     slave  : the serializer itself
// ----------------------------------------------------------------------------
interface cim_act_serializer_if #(
    parameter int unsigned ACT_W = 4,
    parameter int unsigned IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [ACT_W-1:0] act_c;
    logic [ACT_W-1:0] act_d;
    logic             c_n;
    logic             d_n;
    logic             bit_valid;
    logic             out_ready;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_last;
    logic             busy;

    modport master (
        output in_valid, act_c, act_d, out_ready,
        input  in_ready, c_n, d_n, bit_valid, bit_idx, bit_last, busy
    );

    modport slave (
        input  in_valid, act_c, act_d, out_ready,
        output in_ready, c_n, d_n, bit_valid, bit_idx, bit_last, busy
    );
endinterface

// File: rtl/cim_act_serializer.sv
// ----------------------------------------------------------------------------
// cim_act_serializer
//   Bit-serial activation driver for the digital CIM OAI multiplier array.
//   Accepts a pair of ACT_W-bit activation words over a valid/ready handshake
//   and emits them one bit-plane per beat as inverted select bits c_n/d_n,
//   together with the bit index and a last flag for the shift-add accumulator.
//   A new pair can be accepted on the same edge the last beat is consumed, so
//   back-to-back words stream without bubbles.
//
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : cim_act_serializer_if.slave (handshake, words, serial beat bus)
//
//   Parameters:
//     ACT_W : activation word width, 2..16
//     IDX_W : width of bit_idx, >= clog2(ACT_W)
//
//   Build option:
//     CIM_SER_MSB_FIRST_EN : when defined, bits go out MSB first and bit_idx
//                            counts down; otherwise LSB first, counting up.
// ----------------------------------------------------------------------------
module cim_act_serializer #(
    parameter int unsigned ACT_W = 4,
    parameter int unsigned IDX_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cim_act_serializer_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

`ifdef CIM_SER_MSB_FIRST_EN
    localparam int unsigned      FirstBit = ACT_W - 1;
    localparam logic [IDX_W-1:0] IdxFirst = IDX_W'(ACT_W - 1);
    localparam logic [IDX_W-1:0] IdxLast  = '0;
`else
    localparam int unsigned      FirstBit = 0;
    localparam logic [IDX_W-1:0] IdxFirst = '0;
    localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(ACT_W - 1);
`endif

    state_e           state_q;
    logic [ACT_W-1:0] sh_c_q;
    logic [ACT_W-1:0] sh_d_q;
    logic [IDX_W-1:0] idx_q;
    logic             c_n_q;
    logic             d_n_q;
    logic             last_q;

    logic [ACT_W-1:0] sh_c_nxt;
    logic [ACT_W-1:0] sh_d_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             ready;
    logic             load;
    logic             take;

    always_comb begin
        // Ready while idle, or when the last beat is consumed this very edge.
        ready = (state_q == StIdle) || (last_q && bus.out_ready);
        load  = bus.in_valid && ready;
        take  = (state_q == StShift) && bus.out_ready;
        // Rotate rather than shift so the output bit position always holds
        // the next bit; the wrapped-around bits are never presented.
`ifdef CIM_SER_MSB_FIRST_EN
        sh_c_nxt = {sh_c_q[ACT_W-2:0], sh_c_q[ACT_W-1]};
        sh_d_nxt = {sh_d_q[ACT_W-2:0], sh_d_q[ACT_W-1]};
        idx_nxt  = idx_q - IDX_W'(1);
`else
        sh_c_nxt = {sh_c_q[0], sh_c_q[ACT_W-1:1]};
        sh_d_nxt = {sh_d_q[0], sh_d_q[ACT_W-1:1]};
        idx_nxt  = idx_q + IDX_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_c_q  <= '0;
            sh_d_q  <= '0;
            idx_q   <= '0;
            c_n_q   <= 1'b1;
            d_n_q   <= 1'b1;
            last_q  <= 1'b0;
        end else if (load) begin
            // Covers both a load from idle and a load on the completing edge.
            state_q <= StShift;
            sh_c_q  <= bus.act_c;
            sh_d_q  <= bus.act_d;
            idx_q   <= IdxFirst;
            c_n_q   <= ~bus.act_c[FirstBit];
            d_n_q   <= ~bus.act_d[FirstBit];
            last_q  <= 1'b0;
        end else if (take) begin
            if (last_q) begin
                state_q <= StIdle;
                sh_c_q  <= '0;
                sh_d_q  <= '0;
                idx_q   <= '0;
                c_n_q   <= 1'b1;
                d_n_q   <= 1'b1;
                last_q  <= 1'b0;
            end else begin
                sh_c_q  <= sh_c_nxt;
                sh_d_q  <= sh_d_nxt;
                idx_q   <= idx_nxt;
                c_n_q   <= ~sh_c_nxt[FirstBit];
                d_n_q   <= ~sh_d_nxt[FirstBit];
                last_q  <= (idx_nxt == IdxLast);
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.bit_valid = (state_q == StShift);
    assign bus.busy      = (state_q == StShift);
    assign bus.c_n       = c_n_q;
    assign bus.d_n       = d_n_q;
    assign bus.bit_idx   = idx_q;
    assign bus.bit_last  = last_q;

endmodule
